vga_scan_gen: RTL and testbench
===============================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, meaning horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, meaning horizontal sync-pulse pixels.
REQ-004 SHALL have parameter H_BACK, default 48, meaning horizontal back-porch pixels; H_TOTAL = sum of the four H values = 800.
REQ-005 SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2 and V_BACK 33 (lines), with the same meanings vertically; V_TOTAL = 525.
REQ-006 SHALL have port Clk, input, 1, 50 MHz system clock.
REQ-007 SHALL have port Reset, input, 1; one clock, Reset synchronous and active-high.
REQ-008 SHALL have port VGA_CLK, output, 1, 25 MHz pixel clock (Clk/2).
REQ-009 SHALL have port VGA_HS, output, 1, horizontal sync, active-low.
REQ-010 SHALL have port VGA_VS, output, 1, vertical sync, active-low.
REQ-011 SHALL have port VGA_BLANK_N, output, 1, low outside the visible area.
REQ-012 SHALL have port VGA_SYNC_N, output, 1, tied to 0.
REQ-013 SHALL have ports DrawX and DrawY, output, 10 each, current pixel column and row, consumed by the color mapper.
REQ-014 SHALL have port frame_start, output, 1, one-Clk pulse marking the start of each frame.

Function
REQ-015 SHALL keep an internal phase bit pix_en that toggles every Clk; VGA_CLK = registered phase; counters advance only on Clk edges where pix_en=1.
REQ-016 SHALL keep hc in 0..H_TOTAL-1; on advance, hc = H_TOTAL-1 wraps to 0, otherwise hc increments by 1.
REQ-017 SHALL keep vc in 0..V_TOTAL-1; vc advances only when hc wraps; vc = V_TOTAL-1 wraps to 0.
REQ-018 SHALL register all outputs so that DrawX=hc, DrawY=vc, HS, VS and BLANK_N all change on the same Clk edge (zero relative skew).
REQ-019 SHALL drive VGA_HS=0 for H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
REQ-020 SHALL drive VGA_VS=0 for V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1.
REQ-021 SHALL drive VGA_BLANK_N=1 only when hc < H_VISIBLE and vc < V_VISIBLE.
REQ-022 SHALL pulse frame_start high for exactly one Clk on the edge at which hc and vc both wrap to 0 together; the pulse period is H_TOTAL*V_TOTAL*2 = 840000 Clk.
REQ-023 SHALL use counter widths of 10 bits; parameter values above 1023 total are unsupported.

Reset
REQ-024 SHALL, while Reset=1 at a Clk edge, set hc=vc=0, pix_en=0, DrawX=DrawY=0, VGA_HS=VGA_VS=1, VGA_BLANK_N=0 and frame_start=0.
REQ-025 SHALL, when Reset is asserted mid-line or mid-frame, restart from (0,0) on the next edge, with no partial sync pulse extended.
REQ-026 SHALL, on the first pixel advance after Reset is released, emit no frame_start; the first pulse occurs at the first full wrap.

Configuration
REQ-027 SHALL, when VGA_FRAME_COUNT_EN is defined, add output frame_count[15:0], reset to 0, that increments on each frame_start and wraps 65535 -> 0 (game-tick source).
REQ-028 SHALL, when VGA_FRAME_COUNT_EN is undefined, omit the frame_count port and its register entirely.

Structure
REQ-029 SHALL place the default H/V timing constants and H_TOTAL/V_TOTAL in shared package vga_pkg.
REQ-030 SHALL implement the wrap counter as a single sub-module, scan_counter (enable, wrap value, carry out), instantiated twice, once for hc and once for vc.

Verification
REQ-031 SHALL check line timing: after Reset release, hc wraps 799 -> 0 every 1600 Clk, and VGA_HS is low for exactly 192 Clk per line, starting at DrawX=656.
REQ-032 SHALL check vertical timing: VGA_VS is low only while DrawY is 490..491 (3200 Clk), and frame_start pulses every 840000 Clk.
REQ-033 SHALL check blanking: VGA_BLANK_N=0 at DrawX=640 with DrawY=0, at DrawX=0 with DrawY=480, and =1 at (639,479).
REQ-034 SHALL check mid-operation reset: Reset pulsed at DrawX=300, DrawY=200 -> next edge DrawX=DrawY=0, HS=VS=1, BLANK_N=0, and no frame_start pulse.
REQ-035 SHALL check the configuration macro: with VGA_FRAME_COUNT_EN defined and frame_count preloaded by forcing it to 65535, the next frame_start sets frame_count to 0; without the macro, the bench compiles with no frame_count port.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults, counter type and a window-compare helper.
package vga_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // True when lo <= v < hi.
    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Enabled wrap counter: counts 0..wrap_value, flags carry on the wrapping advance.
module scan_counter
    import vga_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic en,
    input  cnt_t wrap_value,
    output cnt_t count,
    output cnt_t count_next,
    output logic carry
);

    cnt_t count_reg;

    always_comb begin
        carry      = en && (count_reg == wrap_value);
        count_next = count_reg;
        if (carry) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel-rate enable, h/v counters, registered sync/blank outputs.
// Optional build macro VGA_FRAME_COUNT_EN adds a 16-bit frame counter output.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
)
(
    input  logic       Clk,
    input  logic       Reset,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam cnt_t H_WRAP   = cnt_t'(LINE_TOTAL - 1);
    localparam cnt_t V_WRAP   = cnt_t'(FRAME_LINES - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic pix_en_reg;
    logic hs_reg;
    logic vs_reg;
    logic blank_n_reg;
    logic frame_start_reg;

    cnt_t hc;
    cnt_t hc_next;
    cnt_t vc;
    cnt_t vc_next;
    logic h_carry;
    logic v_carry;

    scan_counter u_hc (
        .clk        (Clk),
        .srst       (Reset),
        .en         (pix_en_reg),
        .wrap_value (H_WRAP),
        .count      (hc),
        .count_next (hc_next),
        .carry      (h_carry)
    );

    scan_counter u_vc (
        .clk        (Clk),
        .srst       (Reset),
        .en         (h_carry),
        .wrap_value (V_WRAP),
        .count      (vc),
        .count_next (vc_next),
        .carry      (v_carry)
    );

    // Decode from the counters' next values so the decoded outputs land on
    // the same edge as DrawX/DrawY, which are the counter registers themselves.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_en_reg      <= 1'b0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            blank_n_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            pix_en_reg      <= ~pix_en_reg;
            hs_reg          <= ~in_window(hc_next, HS_START, HS_END);
            vs_reg          <= ~in_window(vc_next, VS_START, VS_END);
            blank_n_reg     <= (hc_next < H_VIS) && (vc_next < V_VIS);
            frame_start_reg <= h_carry && v_carry;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_count_reg <= 16'd0;
        end else if (h_carry && v_carry) begin
            frame_count_reg <= frame_count_reg + 16'd1;
        end
    end

    assign frame_count = frame_count_reg;
`endif

    assign VGA_CLK     = pix_en_reg;
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLANK_N = blank_n_reg;
    assign VGA_SYNC_N  = 1'b0;
    assign DrawX       = hc;
    assign DrawY       = vc;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench: default-timing DUT plus a tiny-timing DUT, both checked every Clk
// against a pixel-advance model; vertical jumps use forces on the line counter.
module tb_vga_scan_gen;
    import vga_pkg::*;

    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 4, S_VF = 1, S_VS = 2, S_VB = 2;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a, rst_b;
    logic a_vclk, a_hs, a_vs, a_blank, a_sync, a_fs;
    logic b_vclk, b_hs, b_vs, b_blank, b_sync, b_fs;
    logic [9:0] a_x, a_y, b_x, b_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    vga_scan_gen dut (
        .Clk(clk), .Reset(rst_a), .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_BLANK_N(a_blank), .VGA_SYNC_N(a_sync), .DrawX(a_x), .DrawY(a_y),
        .frame_start(a_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(a_fc)
`endif
    );

    vga_scan_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_s (
        .Clk(clk), .Reset(rst_b), .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_BLANK_N(b_blank), .VGA_SYNC_N(b_sync), .DrawX(b_x), .DrawY(b_y),
        .frame_start(b_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(b_fc)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int b_last = -1;

    // Model: number of pixel advances since reset; position follows by division.
    int hvis [2] = '{DEF_H_VISIBLE, S_HV};
    int hfr  [2] = '{DEF_H_FRONT, S_HF};
    int hsy  [2] = '{DEF_H_SYNC, S_HS};
    int htot [2] = '{H_TOTAL, S_HT};
    int vvis [2] = '{DEF_V_VISIBLE, S_VV};
    int vfr  [2] = '{DEF_V_FRONT, S_VF};
    int vsy  [2] = '{DEF_V_SYNC, S_VS};
    int vtot [2] = '{V_TOTAL, S_VT};
    int adv  [2] = '{0, 0};
    bit ph   [2] = '{1'b0, 1'b0};
    bit rs   [2] = '{1'b1, 1'b1};
    bit fsx  [2] = '{1'b0, 1'b0};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(int i, logic r);
        fsx[i] = 1'b0;
        if (r) begin
            adv[i] = 0;
            ph[i]  = 1'b0;
            rs[i]  = 1'b1;
        end else begin
            if (ph[i]) begin
                adv[i]++;
                fsx[i] = (adv[i] % (htot[i] * vtot[i])) == 0;
            end
            ph[i] = !ph[i];
            rs[i] = 1'b0;
        end
    endtask

    task automatic check_inst(int i, logic [9:0] x, logic [9:0] y, logic hs, logic vs,
                              logic bl, logic fs, logic vclk, logic sync);
        int h, v;
        string p;
        p = (i == 0) ? "a" : "b";
        h = adv[i] % htot[i];
        v = (adv[i] / htot[i]) % vtot[i];
        chk({p, "_x"}, 32'(x), h);
        chk({p, "_y"}, 32'(y), v);
        chk({p, "_hs"}, 32'(hs), 32'(!(h >= hvis[i] + hfr[i] && h < hvis[i] + hfr[i] + hsy[i])));
        chk({p, "_vs"}, 32'(vs), 32'(!(v >= vvis[i] + vfr[i] && v < vvis[i] + vfr[i] + vsy[i])));
        chk({p, "_blank_n"}, 32'(bl), 32'(!rs[i] && h < hvis[i] && v < vvis[i]));
        chk({p, "_frame_start"}, 32'(fs), 32'(fsx[i]));
        chk({p, "_vga_clk"}, 32'(vclk), 32'(ph[i]));
        chk({p, "_sync_n"}, 32'(sync), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, rst_a);
        model_edge(1, rst_b);
        @(negedge clk);
        cyc++;
        check_inst(0, a_x, a_y, a_hs, a_vs, a_blank, a_fs, a_vclk, a_sync);
        check_inst(1, b_x, b_y, b_hs, b_vs, b_blank, b_fs, b_vclk, b_sync);
        if (rst_b) begin
            b_last = -1;
        end else if (b_fs) begin
            if (b_last >= 0) chk("b_frame_period", cyc - b_last, 2 * S_HT * S_VT);
            b_last = cyc;
        end
    endtask

    task automatic run_until(int x, int y, int budget, string tag);
        bit hit;
        hit = (int'(a_x) == x) && (y < 0 || int'(a_y) == y);
        for (int k = 0; k < budget && !hit; k++) begin
            tick();
            hit = (int'(a_x) == x) && (y < 0 || int'(a_y) == y);
        end
        chk({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    // Move the default DUT to line n mid-line, keeping the model in step.
    task automatic jump_a(int n);
        run_until(100, -1, 1700, "jump_sync");
        force dut.u_vc.count_reg = 10'(n);
        adv[0] += (n - (adv[0] / H_TOTAL) % V_TOTAL) * H_TOTAL;
        tick();
        release dut.u_vc.count_reg;
    endtask

    task automatic chk_reset_state(string p);
        chk({p, "_x"}, 32'(a_x), 32'd0);
        chk({p, "_y"}, 32'(a_y), 32'd0);
        chk({p, "_hs"}, 32'(a_hs), 32'd1);
        chk({p, "_vs"}, 32'(a_vs), 32'd1);
        chk({p, "_blank_n"}, 32'(a_blank), 32'd0);
        chk({p, "_frame_start"}, 32'(a_fs), 32'd0);
    endtask

    initial begin
        int hs_low, hs_seen, last_wrap, wraps, vs_low, vs_seen, nfs;
        bit prev_hs, prev_vs, blk_done, hit;
        logic [9:0] prev_x;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2 + $urandom_range(0, 3)) tick();
        chk_reset_state("rst");
        chk("rst_vga_clk", 32'(a_vclk), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Line timing over the first three lines.
        hs_low = 0; hs_seen = 0; last_wrap = -1; wraps = 0; blk_done = 1'b0;
        for (int k = 0; k < 4900; k++) begin
            prev_x = a_x;
            prev_hs = a_hs;
            tick();
            if (!a_hs) hs_low++;
            if (prev_hs && !a_hs) chk("hs_fall_x", 32'(a_x), 32'd656);
            if (!prev_hs && a_hs) begin
                chk("hs_low_clk", hs_low, 192);
                hs_low = 0;
                hs_seen++;
            end
            if (prev_x == 10'd799 && a_x == 10'd0) begin
                if (last_wrap >= 0) chk("line_period", cyc - last_wrap, 1600);
                last_wrap = cyc;
                wraps++;
            end
            if (a_x == 10'd640 && a_y == 10'd0 && !blk_done) begin
                chk("blank_640_0", 32'(a_blank), 32'd0);
                blk_done = 1'b1;
            end
        end
        chk("hs_pulses", hs_seen, 3);
        chk("line_wraps", wraps, 3);
        chk("blank_640_0_seen", 32'(blk_done), 32'd1);

        // Blanking corners at the bottom of the visible area.
        jump_a(478);
        run_until(639, 479, 3500, "pt_639_479");
        chk("blank_639_479", 32'(a_blank), 32'd1);
        run_until(0, 480, 500, "pt_0_480");
        chk("blank_0_480", 32'(a_blank), 32'd0);

        // Vertical sync window.
        jump_a(488);
        vs_low = 0; vs_seen = 0;
        for (int k = 0; k < 7000; k++) begin
            prev_vs = a_vs;
            tick();
            if (!a_vs) begin
                vs_low++;
                chk("vs_row", 32'(int'(a_y) >= 490 && int'(a_y) <= 491), 32'd1);
            end
            if (prev_vs && !a_vs) begin
                chk("vs_fall_y", 32'(a_y), 32'd490);
                chk("vs_fall_x", 32'(a_x), 32'd0);
            end
            if (!prev_vs && a_vs) begin
                chk("vs_low_clk", vs_low, 3200);
                vs_seen++;
            end
        end
        chk("vs_pulses", vs_seen, 1);

        // Frame wrap; with the counter option, preload 65535 and expect rollover.
`ifdef VGA_FRAME_COUNT_EN
        force dut.frame_count_reg = 16'hFFFF;
        tick();
        release dut.frame_count_reg;
        tick();
        chk("fc_preload", 32'(a_fc), 32'hFFFF);
`endif
        jump_a(524);
        hit = a_fs;
        for (int k = 0; k < 3500 && !hit; k++) begin
            tick();
            hit = a_fs;
        end
        chk("frame_start_seen", 32'(hit), 32'd1);
        chk("frame_start_x", 32'(a_x), 32'd0);
        chk("frame_start_y", 32'(a_y), 32'd0);
`ifdef VGA_FRAME_COUNT_EN
        chk("fc_wrap", 32'(a_fc), 32'd0);
`endif
        tick();
        chk("frame_start_width", 32'(a_fs), 32'd0);

        // Mid-frame reset, then mid-HS-pulse reset.
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                jump_a(200);
                run_until(300, 200, 1700, "rst_pt");
            end else begin
                run_until(660 + $urandom_range(0, 80), -1, 1700, "rst_pt_hs");
                chk("hs_low_before_rst", 32'(a_hs), 32'd0);
            end
            rst_a = 1'b1;
            tick();
            chk_reset_state(r == 0 ? "mid_rst" : "hs_rst");
            repeat ($urandom_range(0, 2)) tick();
            rst_a = 1'b0;
            nfs = 0;
            for (int k = 0; k < 1700; k++) begin
                tick();
                if (a_fs) nfs++;
            end
            chk("no_fs_after_rst", nfs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
